// File: rtl/cc_poscomp_pkg.sv
// Shared types and helpers for the multi-row player position comparator.
package cc_poscomp_pkg;

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_HIT      = 2'd1,
        ST_COOLDOWN = 2'd2
    } pcState_t;

    localparam logic MODE_EXACT   = 1'b0;
    localparam logic MODE_OVERLAP = 1'b1;

    // Row-select width; a single-row build still carries a 1-bit index.
    function automatic int rselW(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int cdW(input int cooldown);
        return (cooldown > 1) ? $clog2(cooldown) : 1;
    endfunction

endpackage

// File: rtl/cc_poscomp_rowcmp.sv
// One-row comparator: exact equality or any-common-bit overlap against the player bitmap.
module cc_poscomp_rowcmp
    import cc_poscomp_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 mode,
    input  logic [DATAWIDTH-1:0] row,
    input  logic [DATAWIDTH-1:0] posPlayer,
    output logic                 match
);

    logic isEqual;
    logic isOverlap;

    assign isEqual   = (row == posPlayer);
    // An all-zero operand has no set bit to share, so it can never overlap.
    assign isOverlap = |(row & posPlayer);

    assign match = (mode == MODE_OVERLAP) ? isOverlap : isEqual;

endmodule

// File: rtl/cc_poscomparator_multi.sv
// Registered multi-row position comparator with hit pulse, sticky flag and cooldown.
// Optional saturating hit counter is built when CC_POSCOMP_HITCOUNT_EN is defined.
module cc_poscomparator_multi
    import cc_poscomp_pkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int ROWS         = 4,
    parameter int COOLDOWN     = 16,
    parameter int HITCNT_WIDTH = 4
) (
    input  logic                      CC_POSCOMP_CLOCK_50,
    input  logic                      CC_POSCOMP_RESET_InHigh,
    input  logic                      CC_POSCOMP_clear,
    input  logic                      CC_POSCOMP_enable,
    input  logic                      CC_POSCOMP_mode,
    input  logic [ROWS*DATAWIDTH-1:0] CC_POSCOMP_rows,
    input  logic [DATAWIDTH-1:0]      CC_POSCOMP_posplayer,
    input  logic [rselW(ROWS)-1:0]    CC_POSCOMP_playerrow,
    output logic [ROWS-1:0]           CC_POSCOMP_match,
    output logic                      CC_POSCOMP_hit,
    output logic                      CC_POSCOMP_collided,
    output logic                      CC_POSCOMP_busy,
    output logic [HITCNT_WIDTH-1:0]   CC_POSCOMP_hitcount
);

    localparam int RSEL_W   = rselW(ROWS);
    localparam int SEL_SPAN = 1 << RSEL_W;
    localparam int CD_W     = cdW(COOLDOWN);
    localparam logic [CD_W-1:0] CD_LOAD = (COOLDOWN > 0) ? CD_W'(COOLDOWN - 1) : '0;

    logic [ROWS-1:0]     cmp;
    logic [SEL_SPAN-1:0] cmpPad;
    logic                collisionNow;
    logic                enterHit;

    pcState_t            state;
    logic [CD_W-1:0]     cdCnt;
    logic [ROWS-1:0]     matchReg;
    logic                hitReg;
    logic                busyReg;
    logic                collidedReg;

    for (genvar i = 0; i < ROWS; i++) begin : gRow
        cc_poscomp_rowcmp #(
            .DATAWIDTH (DATAWIDTH)
        ) uRowCmp (
            .mode      (CC_POSCOMP_mode),
            .row       (CC_POSCOMP_rows[i*DATAWIDTH +: DATAWIDTH]),
            .posPlayer (CC_POSCOMP_posplayer),
            .match     (cmp[i])
        );
    end

    // Zero padding up to the full index range makes playerrow >= ROWS select a 0.
    assign cmpPad       = SEL_SPAN'(cmp);
    assign collisionNow = CC_POSCOMP_enable & cmpPad[CC_POSCOMP_playerrow];
    assign enterHit     = (state == ST_ARMED) & collisionNow;

    always_ff @(posedge CC_POSCOMP_CLOCK_50 or posedge CC_POSCOMP_RESET_InHigh) begin
        if (CC_POSCOMP_RESET_InHigh) begin
            state       <= ST_ARMED;
            cdCnt       <= '0;
            matchReg    <= '0;
            hitReg      <= 1'b0;
            busyReg     <= 1'b0;
            collidedReg <= 1'b0;
        end else if (CC_POSCOMP_clear) begin
            state       <= ST_ARMED;
            cdCnt       <= '0;
            matchReg    <= '0;
            hitReg      <= 1'b0;
            busyReg     <= 1'b0;
            collidedReg <= 1'b0;
        end else begin
            if (CC_POSCOMP_enable) begin
                matchReg <= cmp;
            end
            case (state)
                ST_ARMED: begin
                    if (collisionNow) begin
                        state       <= ST_HIT;
                        hitReg      <= 1'b1;
                        busyReg     <= 1'b1;
                        collidedReg <= 1'b1;
                    end
                end
                ST_HIT: begin
                    hitReg <= 1'b0;
                    if (COOLDOWN == 0) begin
                        state   <= ST_ARMED;
                        busyReg <= 1'b0;
                    end else begin
                        state <= ST_COOLDOWN;
                        cdCnt <= CD_LOAD;
                    end
                end
                // Counts clock cycles, independent of the game-tick strobe.
                ST_COOLDOWN: begin
                    if (cdCnt == '0) begin
                        state   <= ST_ARMED;
                        busyReg <= 1'b0;
                    end else begin
                        cdCnt <= cdCnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_ARMED;
                    hitReg  <= 1'b0;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

`ifdef CC_POSCOMP_HITCOUNT_EN
    logic [HITCNT_WIDTH-1:0] hitCnt;

    always_ff @(posedge CC_POSCOMP_CLOCK_50 or posedge CC_POSCOMP_RESET_InHigh) begin
        if (CC_POSCOMP_RESET_InHigh) begin
            hitCnt <= '0;
        end else if (CC_POSCOMP_clear) begin
            hitCnt <= '0;
        end else if (enterHit && (hitCnt != '1)) begin
            hitCnt <= hitCnt + 1'b1;
        end
    end

    assign CC_POSCOMP_hitcount = hitCnt;
`else
    logic unusedEnterHit;
    assign unusedEnterHit      = enterHit;
    assign CC_POSCOMP_hitcount = '0;
`endif

    assign CC_POSCOMP_match    = matchReg;
    assign CC_POSCOMP_hit      = hitReg;
    assign CC_POSCOMP_busy     = busyReg;
    assign CC_POSCOMP_collided = collidedReg;

endmodule

// File: tb/tb_cc_poscomparator_multi.sv
// Directed bench for cc_poscomparator_multi: a 4-row, a 3-row and a 2-bit-counter instance.
module tb_cc_poscomparator_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        enable;
    logic        mode;
    logic [31:0] rows;
    logic [7:0]  pos;
    logic [1:0]  prow;

    logic [3:0] matchA, hcA;
    logic       hitA, colA, busyA;
    logic [2:0] matchB;
    logic [3:0] hcB;
    logic       hitB, colB, busyB;
    logic [3:0] matchC;
    logic [1:0] hcC;
    logic       hitC, colC, busyC;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cc_poscomparator_multi #(.DATAWIDTH(8), .ROWS(4), .COOLDOWN(3), .HITCNT_WIDTH(4)) dutA (
        .CC_POSCOMP_CLOCK_50(clk), .CC_POSCOMP_RESET_InHigh(rst), .CC_POSCOMP_clear(clear),
        .CC_POSCOMP_enable(enable), .CC_POSCOMP_mode(mode), .CC_POSCOMP_rows(rows),
        .CC_POSCOMP_posplayer(pos), .CC_POSCOMP_playerrow(prow), .CC_POSCOMP_match(matchA),
        .CC_POSCOMP_hit(hitA), .CC_POSCOMP_collided(colA), .CC_POSCOMP_busy(busyA),
        .CC_POSCOMP_hitcount(hcA));

    cc_poscomparator_multi #(.DATAWIDTH(8), .ROWS(3), .COOLDOWN(3), .HITCNT_WIDTH(4)) dutB (
        .CC_POSCOMP_CLOCK_50(clk), .CC_POSCOMP_RESET_InHigh(rst), .CC_POSCOMP_clear(clear),
        .CC_POSCOMP_enable(enable), .CC_POSCOMP_mode(mode), .CC_POSCOMP_rows(rows[23:0]),
        .CC_POSCOMP_posplayer(pos), .CC_POSCOMP_playerrow(prow), .CC_POSCOMP_match(matchB),
        .CC_POSCOMP_hit(hitB), .CC_POSCOMP_collided(colB), .CC_POSCOMP_busy(busyB),
        .CC_POSCOMP_hitcount(hcB));

    cc_poscomparator_multi #(.DATAWIDTH(8), .ROWS(4), .COOLDOWN(3), .HITCNT_WIDTH(2)) dutC (
        .CC_POSCOMP_CLOCK_50(clk), .CC_POSCOMP_RESET_InHigh(rst), .CC_POSCOMP_clear(clear),
        .CC_POSCOMP_enable(enable), .CC_POSCOMP_mode(mode), .CC_POSCOMP_rows(rows),
        .CC_POSCOMP_posplayer(pos), .CC_POSCOMP_playerrow(prow), .CC_POSCOMP_match(matchC),
        .CC_POSCOMP_hit(hitC), .CC_POSCOMP_collided(colC), .CC_POSCOMP_busy(busyC),
        .CC_POSCOMP_hitcount(hcC));

    // Expected counter value after n hits for a w-bit counter in this build.
    function automatic int expHc(input int n, input int w);
`ifdef CC_POSCOMP_HITCOUNT_EN
        return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; enable = 1'b0; mode = 1'b0;
        rows = '0; pos = '0; prow = '0;
        tick();
        rst = 1'b0;
        // Create a hit so the reset has something to clear.
        rows = 32'h0000_00AA; pos = 8'hAA; prow = 2'd0; enable = 1'b1;
        tick();
        enable = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++; if (matchA !== 4'b0000) begin bad++; $display("FAIL reset_match got=%b want=0000", matchA); end
        total++; if (hitA !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", hitA); end
        total++; if (colA !== 1'b0) begin bad++; $display("FAIL reset_collided got=%b want=0", colA); end
        total++; if (busyA !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busyA); end
        total++; if (hcA !== 4'd0) begin bad++; $display("FAIL reset_hitcount got=%0d want=0", hcA); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_exact();
        int busyCycles;
        int extraHits;
        doClear();
        mode = 1'b0; rows = 32'h0010_0000; pos = 8'h10; prow = 2'd2; enable = 1'b1;
        tick();
        enable = 1'b0;
        total++; if (matchA !== 4'b0100) begin bad++; $display("FAIL exact_match got=%b want=0100", matchA); end
        total++; if (hitA !== 1'b1) begin bad++; $display("FAIL exact_hit got=%b want=1", hitA); end
        total++; if (colA !== 1'b1) begin bad++; $display("FAIL exact_collided got=%b want=1", colA); end
        total++; if (hcA !== 4'(expHc(1, 4))) begin bad++; $display("FAIL exact_hitcount got=%0d want=%0d", hcA, expHc(1, 4)); end
        busyCycles = (busyA === 1'b1) ? 1 : 0;
        extraHits  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busyA === 1'b1) busyCycles++;
            if (hitA === 1'b1) extraHits++;
        end
        total++; if (busyCycles !== 4) begin bad++; $display("FAIL exact_busy_len got=%0d want=4", busyCycles); end
        total++; if (extraHits !== 0) begin bad++; $display("FAIL exact_hit_len got=%0d extra want=0", extraHits); end
        total++; if (matchA !== 4'b0100) begin bad++; $display("FAIL exact_match_hold got=%b want=0100", matchA); end
        total++; if (colA !== 1'b1) begin bad++; $display("FAIL exact_collided_sticky got=%b want=1", colA); end
    endtask

    task automatic test_mode_contrast();
        doClear();
        mode = 1'b1; rows = 32'h0000_3C00; pos = 8'h04; prow = 2'd1; enable = 1'b1;
        tick();
        enable = 1'b0;
        total++; if (matchA !== 4'b0010) begin bad++; $display("FAIL overlap_match got=%b want=0010", matchA); end
        total++; if (hitA !== 1'b1) begin bad++; $display("FAIL overlap_hit got=%b want=1", hitA); end
        doClear();
        mode = 1'b0; enable = 1'b1;
        tick();
        enable = 1'b0;
        total++; if (matchA !== 4'b0000) begin bad++; $display("FAIL exactmode_match got=%b want=0000", matchA); end
        total++; if (hitA !== 1'b0) begin bad++; $display("FAIL exactmode_hit got=%b want=0", hitA); end
        total++; if (colA !== 1'b0) begin bad++; $display("FAIL exactmode_collided got=%b want=0", colA); end
    endtask

    task automatic test_held();
        int hitIdx[$];
        int expIdx[5] = '{0, 5, 10, 15, 20};
        doClear();
        mode = 1'b0; rows = 32'h0000_0081; pos = 8'h81; prow = 2'd0; enable = 1'b1;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (hitA === 1'b1) hitIdx.push_back(c);
            if (c == 10) begin
                total++; if (hcA !== 4'(expHc(3, 4))) begin bad++; $display("FAIL held_hitcount3 got=%0d want=%0d", hcA, expHc(3, 4)); end
            end
        end
        enable = 1'b0;
        total++; if (hitIdx.size() !== 5) begin bad++; $display("FAIL held_hit_count got=%0d want=5", hitIdx.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < hitIdx.size()) begin
                total++; if (hitIdx[i] !== expIdx[i]) begin bad++; $display("FAIL held_hit_edge%0d got=%0d want=%0d", i, hitIdx[i], expIdx[i]); end
            end
        end
        total++; if (hcA !== 4'(expHc(5, 4))) begin bad++; $display("FAIL held_hitcount5 got=%0d want=%0d", hcA, expHc(5, 4)); end
        total++; if (hcC !== 2'(expHc(5, 2))) begin bad++; $display("FAIL sat_hitcount got=%0d want=%0d", hcC, expHc(5, 2)); end
    endtask

    task automatic test_invalid_row();
        doClear();
        mode = 1'b0; rows = 32'h0055_5555; pos = 8'h55; prow = 2'd3; enable = 1'b1;
        tick();
        enable = 1'b0;
        total++; if (matchB !== 3'b111) begin bad++; $display("FAIL invrow_match got=%b want=111", matchB); end
        total++; if (hitB !== 1'b0) begin bad++; $display("FAIL invrow_hit got=%b want=0", hitB); end
        total++; if (matchA !== 4'b0111) begin bad++; $display("FAIL invrow_matchA got=%b want=0111", matchA); end
        tick();
        total++; if (colB !== 1'b0) begin bad++; $display("FAIL invrow_collided got=%b want=0", colB); end
        total++; if (busyB !== 1'b0) begin bad++; $display("FAIL invrow_busy got=%b want=0", busyB); end
    endtask

    task automatic test_clear_race();
        doClear();
        mode = 1'b0; rows = 32'h0000_0001; pos = 8'h01; prow = 2'd1; enable = 1'b1;
        tick();
        total++; if (matchA !== 4'b0001) begin bad++; $display("FAIL race_premt got=%b want=0001", matchA); end
        prow = 2'd0; clear = 1'b1;
        tick();
        clear = 1'b0; enable = 1'b0;
        total++; if (hitA !== 1'b0) begin bad++; $display("FAIL race_hit got=%b want=0", hitA); end
        total++; if (colA !== 1'b0) begin bad++; $display("FAIL race_collided got=%b want=0", colA); end
        total++; if (hcA !== 4'd0) begin bad++; $display("FAIL race_hitcount got=%0d want=0", hcA); end
        total++; if (matchA !== 4'b0000) begin bad++; $display("FAIL race_match got=%b want=0000", matchA); end
        tick();
        total++; if (hitA !== 1'b0) begin bad++; $display("FAIL race_notqueued got=%b want=0", hitA); end
    endtask

    task automatic test_reset_cooldown();
        mode = 1'b0; rows = 32'h0000_0001; pos = 8'h01; prow = 2'd0; enable = 1'b1;
        tick();
        enable = 1'b0;
        total++; if (hitA !== 1'b1) begin bad++; $display("FAIL rstcd_prehit got=%b want=1", hitA); end
        tick();
        tick();
        total++; if (busyA !== 1'b1) begin bad++; $display("FAIL rstcd_inbusy got=%b want=1", busyA); end
        #2 rst = 1'b1;
        #1;
        total++; if (busyA !== 1'b0) begin bad++; $display("FAIL rstcd_busy got=%b want=0", busyA); end
        total++; if (colA !== 1'b0) begin bad++; $display("FAIL rstcd_collided got=%b want=0", colA); end
        rst = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        total++; if (hitA !== 1'b1) begin bad++; $display("FAIL rstcd_rehit got=%b want=1", hitA); end
        total++; if (hcA !== 4'(expHc(1, 4))) begin bad++; $display("FAIL rstcd_hitcount got=%0d want=%0d", hcA, expHc(1, 4)); end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_mode_contrast();
        test_held();
        test_invalid_row();
        test_clear_race();
        test_reset_cooldown();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cc_poscomparator_multi.md
# cc_poscomparator_multi

Registered, multi-row successor to the single-row player position comparator. Compares one player position bitmap against `ROWS` row bitmaps in either exact-match or overlap mode, and latches the per-row result on each game tick. It turns a collision on the player's current row into a one-cycle hit pulse, a sticky collided flag and a cooldown window. It sits between the row/obstacle generators and the game-control FSM.

## Interface
- `DATAWIDTH`, 8, width of each row bitmap and of the player position
- `ROWS`, 4, number of rows compared in parallel (≥1)
- `COOLDOWN`, 16, cycles spent in COOLDOWN after a hit (0 = no cooldown)
- `HITCNT_WIDTH`, 4, width of the saturating hit counter
- `CC_POSCOMP_CLOCK_50`  in  1  single system clock, rising edge
- `CC_POSCOMP_RESET_InHigh`  in  1  reset, asynchronous and active-high
- `CC_POSCOMP_clear`  in  1  synchronous clear of match, state, collided, hitcount
- `CC_POSCOMP_enable`  in  1  game-tick strobe; inputs are sampled only when high
- `CC_POSCOMP_mode`  in  1  0 = exact equality, 1 = overlap (any common set bit)
- `CC_POSCOMP_rows`  in  ROWS*DATAWIDTH  row i at bits [i*DATAWIDTH +: DATAWIDTH]
- `CC_POSCOMP_posplayer`  in  DATAWIDTH  player position bitmap
- `CC_POSCOMP_playerrow`  in  RSEL_W = max(1,$clog2(ROWS))  row index the player occupies
- `CC_POSCOMP_match`  out  ROWS  registered per-row compare result
- `CC_POSCOMP_hit`  out  1  one-cycle collision pulse
- `CC_POSCOMP_collided`  out  1  sticky collision flag
- `CC_POSCOMP_busy`  out  1  high in HIT or COOLDOWN
- `CC_POSCOMP_hitcount`  out  HITCNT_WIDTH  saturating number of hits

## Operation
- Per-row compare (combinational):
  - mode 0: `row_i == posplayer`
  - mode 1: `|(row_i & posplayer)`; an all-zero operand never overlaps
- `collision_now` = enable & cmp[playerrow]; forced 0 when playerrow ≥ ROWS.
- `match` loads cmp on every edge with enable=1 (in every state) and holds otherwise.
- FSM states are ARMED, HIT and COOLDOWN; reset state is ARMED.
  - ARMED: collision_now → HIT; otherwise stay in ARMED.
  - HIT lasts exactly one cycle. It goes to COOLDOWN with the cooldown counter = COOLDOWN-1, or to ARMED if COOLDOWN==0.
  - COOLDOWN: if counter==0 → ARMED, else decrement. The counter runs on the clock, not on enable.
  - Collisions while in HIT or COOLDOWN are ignored and not queued.
- Outputs:
  - hit = (state==HIT)
  - busy = (state!=ARMED)
  - collided is set on the edge that enters HIT
  - hitcount increments on the edge that enters HIT and saturates at 2^HITCNT_WIDTH-1
- Priority: RESET_InHigh > clear > normal operation. clear forces ARMED, match=0, collided=0, hitcount=0 and cooldown counter=0. An enable in the same cycle as clear is discarded.
- Reset values: match=0, hit=0, collided=0, busy=0, hitcount=0. Reset asserted mid-COOLDOWN returns to ARMED asynchronously.

## Timing
- Enable with collision sampled at edge k:
  - match and state=HIT are valid after edge k
  - hit is high from edge k to edge k+1
  - collided and hitcount update at edge k
- busy stays high for 1+COOLDOWN cycles.
- Earliest next hit edge is k+2+COOLDOWN.
- All outputs are registered; there is no combinational input→output path.

## Configuration
- `CC_POSCOMP_HITCOUNT_EN` defined: the saturating hit counter is implemented as above.
- `CC_POSCOMP_HITCOUNT_EN` undefined: the counter register is removed and the `CC_POSCOMP_hitcount` port stays, tied to 0.
- All other behaviour is identical with or without the macro.

## Structure
- `cc_poscomp_pkg`:
  - state typedef (ARMED, HIT, COOLDOWN)
  - mode constants MODE_EXACT=0, MODE_OVERLAP=1
  - RSEL_W function
- Sub-module `cc_poscomp_rowcmp`: one-row exact/overlap comparator, instantiated ROWS times in a generate loop.
- Top level holds the match register, the FSM, the cooldown counter and the hit counter.

## Test plan
All scenarios use DATAWIDTH=8, ROWS=4, COOLDOWN=3 unless stated otherwise.
- Reset: assert RESET_InHigh asynchronously mid-cycle → match=0, hit=0, collided=0, busy=0, hitcount=0 immediately.
- Exact hit: mode=0, row2=8'h10, posplayer=8'h10, playerrow=2, enable for one cycle → match=4'b0100, hit high for exactly 1 cycle, collided=1, hitcount=1, busy high for 4 cycles.
- Mode contrast: row1=8'h3C, posplayer=8'h04, playerrow=1.
  - mode=1 → match[1]=1 and hit.
  - After clear, the same stimulus with mode=0 → match[1]=0, no hit.
- Held collision with enable=1 continuously → hits at edges k, k+5, k+10 and hitcount=3. With HITCNT_WIDTH=2 and 5 hits → hitcount=3 (saturated).
- Invalid row: ROWS=3, playerrow=3, all rows equal to posplayer → match=3'b111, no hit, collided stays 0.
- Clear and reset races:
  - clear and enable with a collision in the same cycle → no hit, collided=0, hitcount=0, match=0.
  - RESET_InHigh during COOLDOWN → busy=0 at once, and the next collision hits normally.
